gpio_status_collector: RTL and testbench

GPIO_STATUS_COLLECTOR -- requirements
Module: gpio_status_collector

---
 rtl/gpio_status_pkg.sv | 20 ++
 rtl/gpio_edge_sync.sv | 42 ++++
 rtl/gpio_status_collector.sv | 151 +++++++++++++++
 tb/tb_gpio_status_collector.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_status_pkg.sv
// Shared constants and FSM type for the GPIO status collector.
// Holds the channel count and the status_word field positions.
package gpio_status_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    VALID   = 2'd2
  } state_e;

  // status_word field layout: address | done | overrun | busy
  localparam int SW_ADDR_LSB = 0;
  localparam int SW_ADDR_W   = 20;
  localparam int SW_DONE_LSB = 20;
  localparam int SW_OVR_LSB  = 24;
  localparam int SW_BUSY_LSB = 28;

endpackage

// File: rtl/gpio_edge_sync.sv
// Level tap and rising-edge detect for one PS control bit.
// GPIO_STATUS_SYNC_EN inserts a 2-flop synchronizer ahead of the detector.
module gpio_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic prev_q;

`ifdef GPIO_STATUS_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign level_o = sync2_q;
`else
  assign level_o = d_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level_o;
    end
  end

  assign rise_o = level_o & ~prev_q;

endmodule

// File: rtl/gpio_status_collector.sv
// Coherent address snapshot plus sticky done/overrun flags, packed into a GPIO read word.
// Define GPIO_STATUS_SYNC_EN to synchronize snap_req and ack_done into clk.
module gpio_status_collector
  import gpio_status_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ch_0_read_addr_in,
  input  logic [ADDR_W-1:0] ch_1_read_addr_in,
  input  logic [ADDR_W-1:0] ch_2_read_addr_in,
  input  logic [ADDR_W-1:0] ch_3_read_addr_in,
  input  logic [NUM_CH-1:0] busy_in,
  input  logic [NUM_CH-1:0] done_in,
  input  logic              snap_req,
  input  logic [1:0]        sel,
  input  logic [NUM_CH-1:0] ack_done,
  output logic              snap_valid,
  output logic [31:0]       status_word,
  output logic [NUM_CH-1:0] done_flags,
  output logic [NUM_CH-1:0] overrun_flags
);

  state_e state_q, state_d;
  logic armed_q, armed_d;
  logic [ADDR_W-1:0] snap_q [NUM_CH];
  logic [ADDR_W-1:0] addrIn [NUM_CH];
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] ovr_q, ovr_d;
  logic [31:0] status_q, status_d;
  logic [SW_ADDR_W-1:0] selAddr;
  logic snapLevel, snapTrusted, unusedSnapRise;
  logic [NUM_CH-1:0] ackRise, unusedAckLevel;

  assign addrIn[0] = ch_0_read_addr_in;
  assign addrIn[1] = ch_1_read_addr_in;
  assign addrIn[2] = ch_2_read_addr_in;
  assign addrIn[3] = ch_3_read_addr_in;

  gpio_edge_sync uSnapSync (
    .clk_i   (clk),
    .rst_i   (rst),
    .d_i     (snap_req),
    .level_o (snapLevel),
    .rise_o  (unusedSnapRise)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : gAck
    gpio_edge_sync uAckSync (
      .clk_i   (clk),
      .rst_i   (rst),
      .d_i     (ack_done[g]),
      .level_o (unusedAckLevel[g]),
      .rise_o  (ackRise[g])
    );
  end

  // Zeros flushed into the synchronizer by reset are not a real drop of snap_req.
`ifdef GPIO_STATUS_SYNC_EN
  logic [1:0] warm_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      warm_q <= '0;
    end else begin
      warm_q <= {warm_q[0], 1'b1};
    end
  end
  assign snapTrusted = warm_q[1];
`else
  assign snapTrusted = 1'b1;
`endif

  // armed_q remembers a genuine low on snap_req, so each capture needs a fresh rise.
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    if (!snapLevel && snapTrusted) begin
      armed_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (snapLevel && armed_q) begin
          state_d = CAPTURE;
          armed_d = 1'b0;
        end
      end
      CAPTURE: state_d = VALID;
      VALID: begin
        if (!snapLevel) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Set wins over clear; overrun needs a done pulse while the flag is already up.
  always_comb begin
    done_d = (done_q & ~ackRise) | done_in;
    ovr_d  = (ovr_q & ~ackRise) | (done_in & done_q);
  end

  if (ADDR_W >= SW_ADDR_W) begin : gFit
    assign selAddr = snap_q[sel][SW_ADDR_W-1:0];
  end else begin : gExt
    assign selAddr = {{(SW_ADDR_W - ADDR_W){1'b0}}, snap_q[sel]};
  end

  always_comb begin
    status_d = '0;
    status_d[SW_ADDR_LSB +: SW_ADDR_W] = selAddr;
    status_d[SW_DONE_LSB +: NUM_CH]    = done_q;
    status_d[SW_OVR_LSB +: NUM_CH]     = ovr_q;
    status_d[SW_BUSY_LSB +: NUM_CH]    = busy_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      armed_q  <= 1'b0;
      done_q   <= '0;
      ovr_q    <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      status_q <= status_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NUM_CH; n++) begin
        snap_q[n] <= '0;
      end
    end else if (state_q == CAPTURE) begin
      for (int n = 0; n < NUM_CH; n++) begin
        snap_q[n] <= addrIn[n];
      end
    end
  end

  assign snap_valid    = (state_q == VALID);
  assign status_word   = status_q;
  assign done_flags    = done_q;
  assign overrun_flags = ovr_q;

endmodule

// File: tb/tb_gpio_status_collector.sv
// Directed and randomized checks of gpio_status_collector against a behavioural model.
// Latencies follow GPIO_STATUS_SYNC_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_gpio_status_collector;

  localparam int ADDR_W = 20;
`ifdef GPIO_STATUS_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] addr [4];
  logic [3:0]        busy_in;
  logic [3:0]        done_in;
  logic              snap_req;
  logic [1:0]        sel;
  logic [3:0]        ack_done;
  logic              snap_valid;
  logic [31:0]       status_word;
  logic [3:0]        done_flags;
  logic [3:0]        overrun_flags;

  int testCount = 0;
  int failCount = 0;

  // Behavioural model: handshake phase, snapshot copy, flag bits, delayed PS inputs
  int          mPhase;      // 0 waiting, 1 capturing, 2 snapshot held
  bit          mArmed;
  int          mSinceRst;
  logic [19:0] mSnap [4];
  logic [3:0]  mDone, mOvr, mAckPrev;
  logic [31:0] mStatus;
  logic [1:0]  mSnapPipe;
  logic [3:0]  mAckPipe [2];

  gpio_status_collector #(.ADDR_W(ADDR_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .ch_0_read_addr_in (addr[0]),
    .ch_1_read_addr_in (addr[1]),
    .ch_2_read_addr_in (addr[2]),
    .ch_3_read_addr_in (addr[3]),
    .busy_in           (busy_in),
    .done_in           (done_in),
    .snap_req          (snap_req),
    .sel               (sel),
    .ack_done          (ack_done),
    .snap_valid        (snap_valid),
    .status_word       (status_word),
    .done_flags        (done_flags),
    .overrun_flags     (overrun_flags)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance the model by the clock edge about to happen, using the inputs now applied
  task automatic modelStep();
    logic       sSnap;
    logic [3:0] sAck;
    logic [3:0] oldDone;
    bit         rise;
    if (rst) begin
      mPhase = 0; mArmed = 0; mSinceRst = 0;
      mDone = 0; mOvr = 0; mAckPrev = 0; mStatus = 0;
      mSnapPipe = 0; mAckPipe[0] = 0; mAckPipe[1] = 0;
      for (int i = 0; i < 4; i++) mSnap[i] = 0;
      return;
    end
    sSnap = (SYNC == 0) ? snap_req : mSnapPipe[1];
    sAck  = (SYNC == 0) ? ack_done : mAckPipe[1];
    mSnapPipe   = {mSnapPipe[0], snap_req};
    mAckPipe[1] = mAckPipe[0];
    mAckPipe[0] = ack_done;

    mStatus = {busy_in, mOvr, mDone, mSnap[sel]};
    if (mPhase == 1) begin
      for (int i = 0; i < 4; i++) mSnap[i] = addr[i];
    end

    if (!sSnap && mSinceRst >= SYNC) mArmed = 1;
    if (mPhase == 0 && sSnap && mArmed) begin
      mPhase = 1;
      mArmed = 0;
    end else if (mPhase == 1) begin
      mPhase = 2;
    end else if (mPhase == 2 && !sSnap) begin
      mPhase = 0;
    end
    mSinceRst++;

    oldDone = mDone;
    for (int n = 0; n < 4; n++) begin
      rise = sAck[n] && !mAckPrev[n];
      if (rise) begin
        mDone[n] = 0;
        mOvr[n]  = 0;
      end
      if (done_in[n]) begin
        if (oldDone[n]) mOvr[n] = 1;
        mDone[n] = 1;
      end
    end
    mAckPrev = sAck;
  endtask

  // Clock the DUT n times, comparing every output with the model after each edge
  task automatic applyStimulus(input int n);
    for (int c = 0; c < n; c++) begin
      modelStep();
      @(posedge clk);
      #1;
      checkOutput("model_snap_valid", {31'd0, snap_valid}, {31'd0, (mPhase == 2)});
      checkOutput("model_status", status_word, mStatus);
      checkOutput("model_done", {28'd0, done_flags}, {28'd0, mDone});
      checkOutput("model_overrun", {28'd0, overrun_flags}, {28'd0, mOvr});
    end
  endtask

  initial begin
    rst = 1'b1; snap_req = 1'b0; ack_done = '0; done_in = '0; busy_in = '0; sel = '0;
    for (int i = 0; i < 4; i++) addr[i] = '0;

    applyStimulus(2);
    rst = 1'b0;
    checkOutput("reset_snap_valid", {31'd0, snap_valid}, 32'd0);
    checkOutput("reset_status", status_word, 32'd0);
    checkOutput("reset_done", {28'd0, done_flags}, 32'd0);
    checkOutput("reset_overrun", {28'd0, overrun_flags}, 32'd0);
    applyStimulus(2 + SYNC);

    // Snapshot coherence: addresses move right after capture, snapshot must not
    addr[0] = 20'h00010; addr[1] = 20'h00020; addr[2] = 20'h00030; addr[3] = 20'h00040;
    sel = 2'd2; snap_req = 1'b1;
    applyStimulus(1 + SYNC);
    checkOutput("coh_not_yet_valid", {31'd0, snap_valid}, 32'd0);
    applyStimulus(1);
    checkOutput("coh_valid_latency", {31'd0, snap_valid}, 32'd1);
    addr[0] = 20'hAAAAA; addr[1] = 20'hBBBBB; addr[2] = 20'hCCCCC; addr[3] = 20'hDDDDD;
    applyStimulus(1);
    checkOutput("coh_sel2_addr", {12'd0, status_word[19:0]}, 32'h00030);
    sel = 2'd0;
    applyStimulus(1);
    checkOutput("coh_sel0_addr", {12'd0, status_word[19:0]}, 32'h00010);
    snap_req = 1'b0;
    applyStimulus(SYNC);
    checkOutput("coh_valid_hold", {31'd0, snap_valid}, 32'd1);
    applyStimulus(1);
    checkOutput("coh_valid_fall", {31'd0, snap_valid}, 32'd0);

    // Sticky set on two channels, then clear of channel 0 only
    done_in = 4'b0101;
    applyStimulus(1);
    done_in = 4'b0000;
    checkOutput("sticky_set", {28'd0, done_flags}, 32'b0101);
    ack_done = 4'b0001;
    applyStimulus(1);
    ack_done = 4'b0000;
    applyStimulus(SYNC);
    checkOutput("sticky_clear", {28'd0, done_flags}, 32'b0100);
    applyStimulus(1);
    checkOutput("sticky_status_field", {28'd0, status_word[23:20]}, 32'b0100);

    // Overrun on channel 3
    done_in = 4'b1000; applyStimulus(1);
    done_in = 4'b0000; applyStimulus(1);
    done_in = 4'b1000; applyStimulus(1);
    done_in = 4'b0000;
    checkOutput("overrun_set", {28'd0, overrun_flags}, 32'b1000);
    applyStimulus(1);
    checkOutput("overrun_status_bit27", {31'd0, status_word[27]}, 32'd1);
    ack_done = 4'b1000; applyStimulus(1);
    ack_done = 4'b0000; applyStimulus(SYNC);
    checkOutput("overrun_ack_ovr", {28'd0, overrun_flags}, 32'd0);
    checkOutput("overrun_ack_done", {28'd0, done_flags}, 32'b0100);

    // Set beats a simultaneous clear; a held ack clears only once
    ack_done = 4'b0010;
    applyStimulus(SYNC);
    done_in = 4'b0010; applyStimulus(1);
    done_in = 4'b0000;
    checkOutput("set_priority", {31'd0, done_flags[1]}, 32'd1);
    applyStimulus(3);
    checkOutput("held_ack_once", {31'd0, done_flags[1]}, 32'd1);
    done_in = 4'b0010; applyStimulus(1);
    done_in = 4'b0000;
    checkOutput("held_ack_overrun", {31'd0, overrun_flags[1]}, 32'd1);
    ack_done = 4'b0000; applyStimulus(2 + SYNC);
    ack_done = 4'b0010; applyStimulus(1);
    ack_done = 4'b0000; applyStimulus(SYNC + 1);
    checkOutput("reack_done1", {31'd0, done_flags[1]}, 32'd0);
    checkOutput("reack_ovr1", {31'd0, overrun_flags[1]}, 32'd0);

    // Reset while VALID with snap_req still high
    done_in = 4'b1111; applyStimulus(1);
    done_in = 4'b0000; busy_in = 4'b0000;
    snap_req = 1'b1;
    applyStimulus(2 + SYNC);
    checkOutput("rst_mid_valid_before", {31'd0, snap_valid}, 32'd1);
    rst = 1'b1; applyStimulus(1);
    rst = 1'b0;
    checkOutput("rst_mid_snap_valid", {31'd0, snap_valid}, 32'd0);
    checkOutput("rst_mid_status", status_word, 32'd0);
    checkOutput("rst_mid_done", {28'd0, done_flags}, 32'd0);
    checkOutput("rst_mid_overrun", {28'd0, overrun_flags}, 32'd0);
    applyStimulus(6 + SYNC);
    checkOutput("rst_no_recapture", {31'd0, snap_valid}, 32'd0);
    snap_req = 1'b0; applyStimulus(1 + SYNC);
    snap_req = 1'b1; applyStimulus(2 + SYNC);
    checkOutput("rst_recapture", {31'd0, snap_valid}, 32'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      done_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 3) == 0) ack_done = 4'($urandom);
      if ($urandom_range(0, 5) == 0) snap_req = ~snap_req;
      sel = 2'($urandom);
      busy_in = 4'($urandom);
      for (int i = 0; i < 4; i++) addr[i] = 20'($urandom);
      applyStimulus(1);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
